// File: rtl/apb_gpio_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_gpio_master_pkg
//  Description : Shared types for the APB command-stream initiator: FSM state
//                encoding, buffered command record and pointer sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_gpio_master_pkg;

    // Widest address the command record can carry; narrower buses zero-extend.
    localparam int unsigned MAX_ADDR_W    = 64;
    localparam int unsigned DEF_CMD_DEPTH = 4;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned PTR_W = ptr_width(DEF_CMD_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic                  write;
        logic [31:0]           wdata;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_gpio_master_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : apb_gpio_master_fifo
//  Description : Synchronous FIFO of command records. Push is ignored when
//                full and pop is ignored when empty; pointers wrap naturally
//                because DEPTH is a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_gpio_master_fifo
    import apb_gpio_master_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_CMD_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = ptr_width(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_gpio_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_gpio_master
//  Description : APB3 initiator fed by a valid/ready command stream. Commands
//                are queued, issued one at a time as SETUP/ACCESS transfers,
//                and each returns one in-order response (rdata + error).
//                Optional macro APB_MST_TIMEOUT_EN bounds the ACCESS wait to
//                TIMEOUT cycles, completing a stalled transfer with an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_gpio_master
    import apb_gpio_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy
);

    cmd_t              w_push_cmd;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_launch;
    logic              w_pop;
    logic              w_timeout;
    logic              w_done;
    logic              w_unused;

    state_t            r_state;
    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [31:0]       r_pwdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    // Package the incoming command for the queue.
    always_comb begin
        w_push_cmd       = '0;
        w_push_cmd.addr  = MAX_ADDR_W'(cmd_addr);
        w_push_cmd.write = cmd_write;
        w_push_cmd.wdata = cmd_wdata;
    end

    apb_gpio_master_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (pclk),
        .rst     (preset),
        .i_push  (cmd_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A new transfer may start only when the response slot is free (or
    // being emptied this cycle), keeping a single transaction outstanding.
    assign w_launch = !w_empty && (!r_rsp_valid || rsp_ready);
    assign w_pop    = (r_state == IDLE) && w_launch;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 255) ? 16 : 8;

    logic [TO_W-1:0] r_wait;

    // ACCESS wait counter; held at zero outside ACCESS so each entry restarts it.
    always_ff @(posedge pclk) begin
        if (preset || (r_state != ACCESS)) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == ACCESS) && !pready &&
                       ((32'(r_wait) + 32'd1) == 32'(TIMEOUT));
    assign w_unused  = ^{w_head.addr};
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{w_head.addr, (TIMEOUT == 0)};
`endif

    assign w_done = (r_state == ACCESS) && (pready || w_timeout);

    // Transfer sequencing with registered APB and response outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Consumption clears the slot; a completion below overrides it.
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_paddr   <= {w_head.addr[ADDR_W-1:2], 2'b00};
                        r_pwrite  <= w_head.write;
                        r_pwdata  <= w_head.wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (r_pwrite || w_timeout) ? 32'd0 : prdata;
                        r_rsp_err   <= w_timeout || pslverr;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = !w_full;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_empty || (r_state != IDLE) || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_gpio_master
//  Description : Scoreboard bench for apb_gpio_master. Commands are issued
//                by directed sequences and a random phase; a behavioural APB
//                slave with scripted wait states / errors answers transfers,
//                and a monitor checks every response in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_master;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned CMD_DEPTH = 4;
    localparam int unsigned TIMEOUT   = 8;
`ifdef APB_MST_TIMEOUT_EN
    localparam bit TO_HIT = 1'b1;
`else
    localparam bit TO_HIT = 1'b0;
`endif

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;

    apb_gpio_master #(
        .ADDR_W    (ADDR_W),
        .CMD_DEPTH (CMD_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .busy      (busy)
    );

    // Slave script per transfer and expected response per command.
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        int          exp_acc;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          xfer_cnt = 0;
    logic        rr_rand  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Offer one command; the expectation is recorded once acceptance is certain.
    task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input int waits, input logic perr, input logic to);
        plan_t p;
        exp_t  e;
        int    n;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = wr;
        cmd_wdata = wd;
        n = 0;
        @(negedge pclk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge pclk);
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=0 expected 1 within 200 cycles");
        end else begin
            p.addr    = {a[31:2], 2'b00};
            p.wr      = wr;
            p.wdata   = wd;
            p.waits   = waits;
            p.err     = perr;
            p.exp_acc = to ? int'(TIMEOUT) : waits + 1;
            if (to) begin
                e.rdata = 32'd0;
                e.err   = 1'b1;
            end else if (wr) begin
                e.rdata = 32'd0;
                e.err   = perr;
                if (!perr) ref_mem[a[5:2]] = wd;
            end else begin
                e.rdata = ref_mem[a[5:2]];
                e.err   = perr;
            end
            plan_q.push_back(p);
            exp_q.push_back(e);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, busy=%0b, expected 0/0", exp_q.size(), busy);
        end
        step();
    endtask

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Random response back-pressure when enabled.
    initial begin
        forever begin
            @(posedge pclk);
            #1;
            if (rr_rand) rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Behavioural APB slave: follows the script for each transfer.
    initial begin : slave
        plan_t cur;
        int    cnt;
        logic  in_acc;
        in_acc  = 1'b0;
        cnt     = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'd0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                in_acc  = 1'b0;
                pready  = 1'b0;
                pslverr = 1'b0;
            end else if (psel && !penable) begin
                pready  = 1'b0;
                pslverr = 1'b0;
                if (plan_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL setup_unexpected: psel=1 with no command pending");
                    in_acc = 1'b0;
                end else begin
                    cur = plan_q.pop_front();
                    chk("setup_paddr", paddr, cur.addr);
                    chk("setup_pwrite", pwrite, cur.wr);
                    if (cur.wr) chk("setup_pwdata", pwdata, cur.wdata);
                    in_acc = 1'b1;
                    cnt    = 0;
                    xfer_cnt++;
                end
            end else if (psel && penable && in_acc) begin
                cnt++;
                chk("access_paddr", paddr, cur.addr);
                chk("access_pwrite", pwrite, cur.wr);
                if (cnt > cur.waits) begin
                    pready  = 1'b1;
                    pslverr = cur.err;
                    prdata  = slv_mem[paddr[5:2]];
                    if (cur.wr && !cur.err) slv_mem[paddr[5:2]] = pwdata;
                    chk("access_cycles", cnt, cur.exp_acc);
                    in_acc = 1'b0;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'($urandom);
                    prdata  = $urandom;
                end
            end else begin
                if (in_acc) begin
                    chk("access_cycles_abort", cnt, cur.exp_acc);
                    in_acc = 1'b0;
                end
                pready  = 1'b0;
                pslverr = 1'b0;
            end
        end
    end

    // Response monitor: every consumed response must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!preset && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 with no command outstanding");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          x0;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h1000_0000 + i;
            slv_mem[i] = 32'h1000_0000 + i;
        end
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'd0;
        cmd_write = 1'b0;
        cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) step();
        preset = 1'b0;

        // Reset state.
        @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Single write latency.
        step();
        rsp_ready = 1'b1;
        issue(32'h04, 1'b1, 32'hA5, 0, 1'b0, 1'b0);
        @(negedge pclk);
        chk("lat_c0_psel", psel, 0);
        @(negedge pclk);
        chk("lat_c1_psel", psel, 1);
        chk("lat_c1_penable", penable, 0);
        @(negedge pclk);
        chk("lat_c2_penable", penable, 1);
        chk("lat_c2_paddr", paddr, 32'h04);
        chk("lat_c2_pwrite", pwrite, 1);
        chk("lat_c2_pwdata", pwdata, 32'hA5);
        @(negedge pclk);
        chk("lat_c3_rsp_valid", rsp_valid, 1);
        chk("lat_c3_rsp_err", rsp_err, 0);
        chk("lat_c3_rsp_rdata", rsp_rdata, 0);
        step();
        drain();

        // Read with three wait states; low address bits ignored.
        issue(32'h50, 1'b1, 32'h3C, 0, 1'b0, 1'b0);
        issue(32'h53, 1'b0, 32'h0, 3, 1'b0, 1'b0);
        drain();
        chk("read_ws_rdata", rsp_rdata, 32'h3C);

        // Slave error on a write, following commands unaffected.
        issue(32'h20, 1'b1, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);
        issue(32'h20, 1'b0, 32'h0, 1, 1'b0, 1'b0);
        issue(32'h20, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0);
        issue(32'h22, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        drain();

        // Fill the queue while responses are held off.
        rsp_ready = 1'b0;
        x0 = xfer_cnt;
        issue(32'h08, 1'b1, 32'h0000_0011, 0, 1'b0, 1'b0);
        issue(32'h0C, 1'b1, 32'h0000_0022, 0, 1'b0, 1'b0);
        issue(32'h08, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        issue(32'h0C, 1'b0, 32'h0, 1, 1'b0, 1'b0);
        issue(32'h10, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        @(negedge pclk);
        chk("fill_cmd_ready", cmd_ready, 0);
        repeat (6) step();
        @(negedge pclk);
        chk("fill_one_xfer", xfer_cnt - x0, 1);
        chk("fill_rsp_valid", rsp_valid, 1);
        chk("fill_psel", psel, 0);
        chk("fill_cmd_ready_hold", cmd_ready, 0);
        chk("fill_busy", busy, 1);
        step();
        rsp_ready = 1'b1;
        drain();

        // Reset during ACCESS with two commands queued.
        issue(32'h14, 1'b0, 32'h0, 30, 1'b0, 1'b0);
        issue(32'h18, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        issue(32'h1C, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        chk("rst_mid_in_access", penable, 1);
        preset = 1'b1;
        plan_q.delete();
        exp_q.delete();
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_penable", penable, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        step();
        preset = 1'b0;
        repeat (5) step();
        @(negedge pclk);
        chk("rst_after_rsp_valid", rsp_valid, 0);
        chk("rst_after_busy", busy, 0);
        step();

        // Stalled slave: timeout when enabled, otherwise a long wait.
        issue(32'h30, 1'b0, 32'h0, 20, 1'b0, TO_HIT);
        drain();
        issue(32'h34, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        drain();

        // Randomized traffic with random back-pressure, waits and errors.
        rr_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            issue(a, 1'($urandom), $urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        drain();
        rr_rand   = 1'b0;
        rsp_ready = 1'b1;
        chk("end_plans_left", plan_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
